// File: rtl/dequant_4x4.sv
// Inverse quantizer for one 4x4 block: scales zig-zag ordered levels by the H.264 LevelScale
// factor and stores them in raster order. Optional output saturation via `DEQUANT_SAT_EN.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_LOAD | accepting levels into the buffer (in_ready=1)
// S_FULL | complete block presented on out_coef (out_valid=1)

module dequant_4x4 #(
   parameter int BIT_LENGTH = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [BIT_LENGTH:0]   in_coef,
   input  logic                         in_last,
   input  logic [5:0]                   qp,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [BIT_LENGTH:0]   out_coef [16]
);

   typedef enum logic {
      S_LOAD = 1'b0,
      S_FULL = 1'b1
   } state_t;

   state_t                      state_q, state_d;
   logic [3:0]                  k_q, k_d;
   logic [5:0]                  qp_r;
   logic [5:0]                  qp_cl;
   logic [5:0]                  qp_use;
   logic [3:0]                  qp_div;
   logic [2:0]                  qp_mod;
   logic [3:0]                  raster;
   logic [4:0]                  v_sel;
   logic                        accept;
   logic                        out_hs;
   logic signed [31:0]          prod;
   logic signed [31:0]          scaled;
   logic signed [BIT_LENGTH:0]  coef_w;
   logic signed [BIT_LENGTH:0]  buf_q [16];

   function automatic logic [3:0] zz_map(input logic [3:0] k);
      logic [3:0] r;
      case (k)
         4'd0:    r = 4'd0;
         4'd1:    r = 4'd1;
         4'd2:    r = 4'd4;
         4'd3:    r = 4'd8;
         4'd4:    r = 4'd5;
         4'd5:    r = 4'd2;
         4'd6:    r = 4'd3;
         4'd7:    r = 4'd6;
         4'd8:    r = 4'd9;
         4'd9:    r = 4'd12;
         4'd10:   r = 4'd13;
         4'd11:   r = 4'd10;
         4'd12:   r = 4'd7;
         4'd13:   r = 4'd11;
         4'd14:   r = 4'd14;
         default: r = 4'd15;
      endcase
      return r;
   endfunction

   // Repeated subtraction; qp is already clamped to 0..51, so eight steps always suffice.
   function automatic logic [6:0] qp_split(input logic [5:0] q);
      logic [5:0] rem;
      logic [3:0] quo;
      rem = q;
      quo = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (rem >= 6'd6) begin
            rem = rem - 6'd6;
            quo = quo + 4'd1;
         end
      end
      return {quo, 3'(rem)};
   endfunction

   // cls: 0 = both even, 1 = mixed, 2 = both odd
   function automatic logic [4:0] v_lookup(input logic [2:0] m, input logic [1:0] cls);
      logic [4:0] v;
      case (m)
         3'd0:    v = (cls == 2'd0) ? 5'd10 : (cls == 2'd1) ? 5'd13 : 5'd16;
         3'd1:    v = (cls == 2'd0) ? 5'd11 : (cls == 2'd1) ? 5'd14 : 5'd18;
         3'd2:    v = (cls == 2'd0) ? 5'd13 : (cls == 2'd1) ? 5'd16 : 5'd20;
         3'd3:    v = (cls == 2'd0) ? 5'd14 : (cls == 2'd1) ? 5'd18 : 5'd23;
         3'd4:    v = (cls == 2'd0) ? 5'd16 : (cls == 2'd1) ? 5'd20 : 5'd25;
         default: v = (cls == 2'd0) ? 5'd18 : (cls == 2'd1) ? 5'd23 : 5'd29;
      endcase
      return v;
   endfunction

   always_comb begin
      qp_cl          = (qp > 6'd51) ? 6'd51 : qp;
      qp_use         = (k_q == 4'd0) ? qp_cl : qp_r;
      {qp_div, qp_mod} = qp_split(qp_use);
      raster         = zz_map(k_q);
      // raster[2] is row parity, raster[0] is column parity
      if (!raster[2] && !raster[0])
         v_sel = v_lookup(qp_mod, 2'd0);
      else if (raster[2] && raster[0])
         v_sel = v_lookup(qp_mod, 2'd2);
      else
         v_sel = v_lookup(qp_mod, 2'd1);
      prod   = 32'(in_coef) * $signed({27'd0, v_sel});
      scaled = prod <<< qp_div;
   end

`ifdef DEQUANT_SAT_EN
   localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< BIT_LENGTH) - 32'sd1;
   localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< BIT_LENGTH);

   always_comb begin
      if (scaled > SAT_MAX)
         coef_w = SAT_MAX[BIT_LENGTH:0];
      else if (scaled < SAT_MIN)
         coef_w = SAT_MIN[BIT_LENGTH:0];
      else
         coef_w = scaled[BIT_LENGTH:0];
   end
`else
   logic unused_scaled_hi;

   assign coef_w           = scaled[BIT_LENGTH:0];
   assign unused_scaled_hi = ^scaled[31:BIT_LENGTH+1];
`endif

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (k_q == 4'd15 || in_last) begin
                  state_d = S_FULL;
                  k_d     = 4'd0;
               end else begin
                  k_d = k_q + 4'd1;
               end
            end
         end
         default: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_LOAD;
               k_d     = 4'd0;
            end
         end
      endcase
   end

   assign accept = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;

   // Clearing on the output handshake is what makes early-terminated blocks zero-filled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_LOAD;
         k_q     <= 4'd0;
         qp_r    <= 6'd0;
         for (int i = 0; i < 16; i++)
            buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (accept && k_q == 4'd0)
            qp_r <= qp_cl;
         if (out_hs) begin
            for (int i = 0; i < 16; i++)
               buf_q[i] <= '0;
         end else if (accept) begin
            buf_q[raster] <= coef_w;
         end
      end
   end

   assign out_coef = buf_q;

endmodule

// File: tb/tb_dequant_4x4.sv
// Directed bench for dequant_4x4: mapping, scaling, early end, overflow, backpressure and reset.
module tb_dequant_4x4;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_coef;
   logic               in_last;
   logic [5:0]         qp;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_coef [16];

   logic signed [15:0] levels [16];
   int n_checks;
   int n_fail;

   dequant_4x4 #(.BIT_LENGTH(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coef   (in_coef),
      .in_last   (in_last),
      .qp        (qp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coef  (out_coef)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // LevelScale at qp%6==0 for a raster index
   function automatic int v0(input int idx);
      int r;
      int c;
      r = idx / 4;
      c = idx % 4;
      if ((r % 2 == 0) && (c % 2 == 0)) return 10;
      if ((r % 2 == 1) && (c % 2 == 1)) return 16;
      return 13;
   endfunction

   // Drives levels[first..n-1]; qp is only meaningful on level 0, so later levels carry junk qp.
   task automatic send_block(input int first, input int n, input logic [5:0] q, input logic use_last);
      for (int i = first; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_coef  = levels[i];
         qp       = (i == 0) ? q : 6'd50;
         in_last  = use_last && (i == n - 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic consume;
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL consume_ready: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_coef   = '0;
      in_last   = 1'b0;
      qp        = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_flags: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (out_coef[i] !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_coef[%0d]: got %0d, required 0", i, out_coef[i]);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_zigzag;
      int exp_v [16];
      for (int i = 0; i < 16; i++) levels[i] = 16'sd1;
      send_block(0, 15, 6'd0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zz_early_valid: out_valid=%b after 15 levels, required 0", out_valid);
      end
      send_block(15, 16, 6'd0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL zz_latency: out_valid=%b one cycle after 16th level, required 1", out_valid);
      end
      exp_v = '{10, 13, 10, 13, 13, 16, 13, 16, 10, 13, 10, 13, 13, 16, 13, 16};
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (out_coef[i] !== 16'(exp_v[i])) begin
            n_fail++;
            $display("FAIL zz_out[%0d]: got %0d, required %0d", i, out_coef[i], exp_v[i]);
         end
      end
      consume();
   endtask

   task automatic test_mapping;
      for (int i = 0; i < 16; i++) levels[i] = 16'(i + 1);
      send_block(0, 16, 6'd0, 1'b0);
      n_checks++;
      if (out_coef[4] !== 16'sd39) begin
         n_fail++;
         $display("FAIL map_out4: got %0d, required 39", out_coef[4]);
      end
      n_checks++;
      if (out_coef[8] !== 16'sd40) begin
         n_fail++;
         $display("FAIL map_out8: got %0d, required 40", out_coef[8]);
      end
      n_checks++;
      if (out_coef[15] !== 16'sd256) begin
         n_fail++;
         $display("FAIL map_out15: got %0d, required 256", out_coef[15]);
      end
      n_checks++;
      if (out_coef[1] !== 16'sd26 || out_coef[0] !== 16'sd10) begin
         n_fail++;
         $display("FAIL map_out01: got %0d/%0d, required 10/26", out_coef[0], out_coef[1]);
      end
      n_checks++;
      if (out_coef[12] !== 16'sd130) begin
         n_fail++;
         $display("FAIL map_out12: got %0d, required 130", out_coef[12]);
      end
      consume();
   endtask

   task automatic test_early_end;
      levels[0] = 16'sd3;
      send_block(0, 1, 6'd28, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_coef[0] !== 16'sd768) begin
         n_fail++;
         $display("FAIL early_out0: valid=%b coef=%0d, required 1/768", out_valid, out_coef[0]);
      end
      for (int i = 1; i < 16; i++) begin
         n_checks++;
         if (out_coef[i] !== 16'sd0) begin
            n_fail++;
            $display("FAIL early_stale[%0d]: got %0d, required 0", i, out_coef[i]);
         end
      end
      consume();
      n_checks++;
      if (out_coef[0] !== 16'sd0) begin
         n_fail++;
         $display("FAIL early_cleared: got %0d, required 0", out_coef[0]);
      end
   endtask

   task automatic test_overflow;
      logic signed [15:0] exp_pos;
      logic signed [15:0] exp_neg;
`ifdef DEQUANT_SAT_EN
      exp_pos = 16'sd32767;
      exp_neg = -16'sd32768;
`else
      exp_pos = 16'sd30720;
      exp_neg = -16'sd30720;
`endif
      levels[0] = 16'sd100;
      send_block(0, 1, 6'd51, 1'b1);
      n_checks++;
      if (out_coef[0] !== exp_pos) begin
         n_fail++;
         $display("FAIL ovf_pos: got %0d, required %0d", out_coef[0], exp_pos);
      end
      consume();
      levels[0] = -16'sd100;
      send_block(0, 1, 6'd51, 1'b1);
      n_checks++;
      if (out_coef[0] !== exp_neg) begin
         n_fail++;
         $display("FAIL ovf_neg: got %0d, required %0d", out_coef[0], exp_neg);
      end
      consume();
      // qp 63 behaves as 51: 1*14<<8
      levels[0] = 16'sd1;
      send_block(0, 1, 6'd63, 1'b1);
      n_checks++;
      if (out_coef[0] !== 16'sd3584) begin
         n_fail++;
         $display("FAIL qp_clamp: got %0d, required 3584", out_coef[0]);
      end
      consume();
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < 16; i++) levels[i] = 16'sd1;
      send_block(0, 16, 6'd0, 1'b0);
      for (int cyc = 0; cyc < 5; cyc++) begin
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_flags cyc%0d: out_valid=%b in_ready=%b, required 1/0", cyc, out_valid, in_ready);
         end
         for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (out_coef[i] !== 16'(v0(i))) begin
               n_fail++;
               $display("FAIL bp_hold cyc%0d [%0d]: got %0d, required %0d", cyc, i, out_coef[i], v0(i));
            end
         end
         in_valid = 1'b1;
         in_last  = 1'b1;
         in_coef  = 16'sd999;
         qp       = 6'd0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      consume();
      // any consumed pulse would have shifted k or filled the buffer
      levels[0] = 16'sd5;
      send_block(0, 1, 6'd0, 1'b1);
      n_checks++;
      if (out_coef[0] !== 16'sd50 || out_coef[1] !== 16'sd0) begin
         n_fail++;
         $display("FAIL bp_no_consume: got %0d/%0d, required 50/0", out_coef[0], out_coef[1]);
      end
      consume();
   endtask

   task automatic test_reset_midblock;
      for (int i = 0; i < 16; i++) levels[i] = 16'sd1;
      send_block(0, 7, 6'd0, 1'b0);
      reset = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_flags: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (out_coef[i] !== 16'sd0) begin
            n_fail++;
            $display("FAIL rst_mid_coef[%0d]: got %0d, required 0", i, out_coef[i]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      levels[0] = 16'sd7;
      send_block(0, 16, 6'd6, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_coef[0] !== 16'sd140) begin
         n_fail++;
         $display("FAIL rst_next_out0: valid=%b coef=%0d, required 1/140", out_valid, out_coef[0]);
      end
      n_checks++;
      if (out_coef[1] !== 16'sd26 || out_coef[15] !== 16'sd32) begin
         n_fail++;
         $display("FAIL rst_next_out1_15: got %0d/%0d, required 26/32", out_coef[1], out_coef[15]);
      end
      consume();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_zigzag();
      test_mapping();
      test_early_end();
      test_overflow();
      test_backpressure();
      test_reset_midblock();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
